ice40_audio_frame_detect: RTL and testbench
===========================================

Name: ice40_audio_frame_detect

Overview:
- Front-end stage that directly feeds the audio clock-gating controller.
- Accumulates absolute sample amplitude over fixed-length frames and compares each frame's energy against a programmable threshold.
- Applies a hang-over window, then raises `o_active`. This is the `i_active` request that un-gates the core clock and launches the filterbank/ML pass.
- Holds the request until the controller signals frame consumption via `i_start_fb`.

Parameters:
- SAMPLE_W, 16, signed two's-complement sample width.
- FRAME_LEN, 256, valid samples per frame; any value ≥ 2, need not be a power of two.
- ENERGY_W, SAMPLE_W+$clog2(FRAME_LEN), accumulator/energy/threshold width (derived; not overridden).
- HANG_FRAMES, 4, number of trailing below-threshold frames still flagged active after the last above-threshold frame (0 = no hang).

Ports:
- i_clk, input, 1, single block clock; all logic on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- i_enable, input, 1, detector enable; low = idle and clear.
- i_sample_valid, input, 1, qualifies `i_sample` for one cycle.
- i_sample, input, SAMPLE_W, signed audio sample.
- i_threshold, input, ENERGY_W, unsigned energy threshold; sampled only at frame end.
- i_start_fb, input, 1, level from clock controller, synchronous to `i_clk`; its rising edge means the pending frame is consumed.
- o_active, output, 1, frame pending / voice-active request to clock controller.
- o_frame_done, output, 1, one-cycle pulse per completed frame.
- o_energy, output, ENERGY_W, energy of last completed frame.
- o_overrun, output, 1, one-cycle pulse: triggering frame completed while previous still pending.
- o_hang, output, $clog2(HANG_FRAMES+1), current hang counter (debug).

Behaviour:
- Reset values:
  - All outputs 0.
  - Accumulator 0, sample count 0, hang 0, pending 0, start_fb edge register 0, state S_IDLE.
- States: S_IDLE, S_ACC.
  - S_IDLE → S_ACC when `i_enable`=1.
  - S_ACC → S_IDLE when `i_enable`=0.
  - Entering S_IDLE clears accumulator, count, hang and pending (so `o_active`=0). `o_energy` holds its value.
- Magnitude: |s| with -2^(SAMPLE_W-1) saturated to 2^(SAMPLE_W-1)-1. Zero-extend to ENERGY_W. The accumulator cannot overflow.
- Samples are accepted only in S_ACC with `i_sample_valid`=1. Valid pulses while in S_IDLE are ignored.
- Non-final sample: acc += |s|; count += 1.
- Final sample (count == FRAME_LEN-1), accepted at cycle N. Compute total = acc + |s| combinationally. At edge N+1:
  - `o_energy` <= total.
  - `o_frame_done` = 1 for one cycle.
  - acc <= 0, count <= 0.
- Back-to-back valid samples are never dropped. A sample at N+1 is the first sample of the next frame.
- Trigger decision at frame end, using `i_threshold` at cycle N:
  - total ≥ threshold: hang <= HANG_FRAMES; trigger = 1.
  - Otherwise, hang > 0: hang <= hang-1; trigger = 1.
  - Otherwise: trigger = 0.
- Pending handshake:
  - trigger = 1 sets pending at N+1.
  - A rising edge of `i_start_fb` (registered previous-value compare) clears pending.
  - `o_active` = pending, a registered output.
  - Frame-end trigger and consume edge in the same cycle: pending stays 1, no overrun.
  - Trigger while pending already 1 and no consume edge: pending stays 1; `o_overrun` pulses at N+1.
- A falling edge or steady level of `i_start_fb` has no effect.
- `i_enable` falling mid-frame aborts the partial frame. No `o_frame_done` is issued.
- `reset` mid-frame: everything returns to reset values immediately.

Test Plan:
1. FRAME_LEN=8, HANG=0, threshold=100, eight samples of +20 back-to-back → `o_frame_done` and `o_energy`=160 one cycle after the 8th sample; `o_active`=1 the same cycle; `i_start_fb` 0→1 → `o_active`=0 next cycle.
2. Same setup with samples alternating -10/+10 → energy=80; `o_active` stays 0; a -32768 sample contributes 32767.
3. HANG=2, threshold=100: one frame at 160, then three frames at 0, each consumed → `o_active` set after frames 1, 2, 3; not after frame 4; `o_hang` sequence 2,1,0,0.
4. Two triggering frames, no `i_start_fb` → `o_overrun` pulses once at end of frame 2; `o_active` stays 1; one consume edge clears it.
5. Consume edge coincident with frame-end trigger → `o_active` remains 1, `o_overrun`=0.
6. `i_enable` dropped after 5 samples, re-raised, 8 samples of 20 → single `o_frame_done` with energy=160 (partial discarded). Async `reset` mid-frame → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/ice40_audio_frame_detect.sv
// Frame-energy voice-activity detector: sums |sample| over fixed frames, applies
// threshold plus hang-over, and holds o_active until the clock controller consumes it.
module ice40_audio_frame_detect #(
  parameter int SAMPLE_W    = 16,
  parameter int FRAME_LEN   = 256,
  parameter int ENERGY_W    = SAMPLE_W + $clog2(FRAME_LEN),
  parameter int HANG_FRAMES = 4,
  localparam int HANG_W     = (HANG_FRAMES > 0) ? $clog2(HANG_FRAMES + 1) : 1
) (
  input  logic                i_clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [ENERGY_W-1:0] i_threshold,
  input  logic                i_start_fb,
  output logic                o_active,
  output logic                o_frame_done,
  output logic [ENERGY_W-1:0] o_energy,
  output logic                o_overrun,
  output logic [HANG_W-1:0]   o_hang
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t              state_q;
  logic [ENERGY_W-1:0] acc_q;
  logic [CNT_W-1:0]    count_q;
  logic [HANG_W-1:0]   hang_q;
  logic                pending_q;
  logic                start_fb_q;
  logic                frame_done_q;
  logic                overrun_q;
  logic [ENERGY_W-1:0] energy_q;

  logic [SAMPLE_W-1:0] mag;
  logic [ENERGY_W-1:0] acc_d;
  logic [HANG_W-1:0]   hang_d;
  logic                sample_accept;
  logic                last_sample;
  logic                above;
  logic                trigger;
  logic                consume;

  // Most-negative sample saturates so the magnitude still fits in SAMPLE_W-1 bits.
  always_comb begin
    mag = i_sample;
    if (i_sample[SAMPLE_W-1]) begin
      if (i_sample == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
        mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end else begin
        mag = -i_sample;
      end
    end
  end

  assign sample_accept = (state_q == S_ACC) && i_enable && i_sample_valid;
  assign last_sample   = sample_accept && (count_q == CNT_W'(FRAME_LEN - 1));
  assign acc_d         = acc_q + {{(ENERGY_W-SAMPLE_W){1'b0}}, mag};
  assign above         = (acc_d >= i_threshold);
  assign consume       = i_start_fb && !start_fb_q;

  always_comb begin
    hang_d  = hang_q;
    trigger = 1'b0;
    if (above) begin
      hang_d  = HANG_W'(HANG_FRAMES);
      trigger = 1'b1;
    end else if (hang_q != '0) begin
      hang_d  = hang_q - HANG_W'(1);
      trigger = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      hang_q       <= '0;
      pending_q    <= 1'b0;
      start_fb_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      energy_q     <= '0;
    end else begin
      start_fb_q   <= i_start_fb;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          acc_q     <= '0;
          count_q   <= '0;
          hang_q    <= '0;
          pending_q <= 1'b0;
          if (i_enable) begin
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          if (!i_enable) begin
            // Abort any partial frame; energy of the last full frame is kept.
            state_q   <= S_IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            hang_q    <= '0;
            pending_q <= 1'b0;
          end else begin
            if (last_sample) begin
              acc_q        <= '0;
              count_q      <= '0;
              energy_q     <= acc_d;
              frame_done_q <= 1'b1;
              hang_q       <= hang_d;
            end else if (sample_accept) begin
              acc_q   <= acc_d;
              count_q <= count_q + CNT_W'(1);
            end
            // A new trigger wins over a simultaneous consume edge.
            if (last_sample && trigger) begin
              pending_q <= 1'b1;
              overrun_q <= pending_q && !consume;
            end else if (consume) begin
              pending_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_active     = pending_q;
  assign o_frame_done = frame_done_q;
  assign o_energy     = energy_q;
  assign o_overrun    = overrun_q;
  assign o_hang       = hang_q;

endmodule

// File: tb/tb_ice40_audio_frame_detect.sv
// Scoreboard bench for ice40_audio_frame_detect: directed scenarios plus random traffic
// checked against a frame-level reference model.
module tb_ice40_audio_frame_detect;

  localparam int SW   = 16;
  localparam int FLEN = 8;
  localparam int HANG = 2;
  localparam int EW   = SW + $clog2(FLEN);
  localparam int HW   = $clog2(HANG + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_sample_valid = 1'b0;
  logic [SW-1:0] i_sample = '0;
  logic [EW-1:0] i_threshold = '0;
  logic          i_start_fb = 1'b0;
  logic          o_active;
  logic          o_frame_done;
  logic [EW-1:0] o_energy;
  logic          o_overrun;
  logic [HW-1:0] o_hang;

  ice40_audio_frame_detect #(
    .SAMPLE_W(SW), .FRAME_LEN(FLEN), .HANG_FRAMES(HANG)
  ) dut (
    .i_clk(clk), .reset(reset), .i_enable(i_enable), .i_sample_valid(i_sample_valid),
    .i_sample(i_sample), .i_threshold(i_threshold), .i_start_fb(i_start_fb),
    .o_active(o_active), .o_frame_done(o_frame_done), .o_energy(o_energy),
    .o_overrun(o_overrun), .o_hang(o_hang)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit done;
    int energy;
    bit active;
    bit overrun;
    int hang;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: frame contents as a list of magnitudes
  bit   m_in_acc;
  int   m_frame[$];
  int   m_hang;
  bit   m_pending;
  bit   m_prev_sfb;
  int   m_energy;
  int   thr = 100;
  bit   sfb = 1'b0;

  function automatic void chk(string name, longint act, longint exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endfunction

  function automatic void model_reset();
    m_in_acc = 0; m_frame.delete(); m_hang = 0; m_pending = 0;
    m_prev_sfb = 0; m_energy = 0;
  endfunction

  function automatic exp_t model_step(bit en, bit vld, int s);
    exp_t e;
    bit   consume;
    bit   trig;
    int   mag;
    int   total;
    consume = sfb && !m_prev_sfb;
    m_prev_sfb = sfb;
    e.done = 0;
    e.overrun = 0;
    trig = 0;
    if (!m_in_acc) begin
      if (en) m_in_acc = 1;
    end else if (!en) begin
      m_in_acc = 0; m_frame.delete(); m_hang = 0; m_pending = 0;
    end else begin
      if (vld) begin
        mag = (s < 0) ? -s : s;
        if (mag > 32767) mag = 32767;
        m_frame.push_back(mag);
        if (m_frame.size() == FLEN) begin
          total = m_frame.sum();
          m_frame.delete();
          m_energy = total;
          e.done = 1;
          if (total >= thr) begin
            m_hang = HANG; trig = 1;
          end else if (m_hang > 0) begin
            m_hang--; trig = 1;
          end
        end
      end
      if (trig) begin
        e.overrun = m_pending && !consume;
        m_pending = 1;
      end else if (consume) begin
        m_pending = 0;
      end
    end
    e.energy = m_energy;
    e.active = m_pending;
    e.hang   = m_hang;
    return e;
  endfunction

  task automatic step(input bit en, input bit vld, input int s);
    @(negedge clk);
    i_enable       = en;
    i_sample_valid = vld;
    i_sample       = s[SW-1:0];
    i_threshold    = thr[EW-1:0];
    i_start_fb     = sfb;
    sb.push_back(model_step(en, vld, s));
  endtask

  task automatic frame(input int v);
    for (int k = 0; k < FLEN; k++) step(1, 1, v);
  endtask

  task automatic consume_pulse();
    sfb = 1; step(1, 0, 0);
    sfb = 0; step(1, 0, 0);
  endtask

  task automatic clear_det();
    step(0, 0, 0);
    step(1, 0, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_active"}, o_active, 0);
    chk({tag, "_frame_done"}, o_frame_done, 0);
    chk({tag, "_energy"}, o_energy, 0);
    chk({tag, "_overrun"}, o_overrun, 0);
    chk({tag, "_hang"}, o_hang, 0);
  endtask

  // Assert reset between edges, once the monitor has drained the last expectation.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    sfb = 0;
    i_enable = 0; i_sample_valid = 0; i_start_fb = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: one expectation per driven cycle, checked just after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("frame_done", o_frame_done, e.done);
        chk("active", o_active, e.active);
        chk("overrun", o_overrun, e.overrun);
        chk("hang", o_hang, e.hang);
        chk("energy", o_energy, e.energy);
      end else if (o_frame_done || o_overrun) begin
        chk("spurious_pulse", {o_frame_done, o_overrun}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit en;
    bit vld;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic trigger and consume
    thr = 100;
    step(1, 0, 0);
    frame(20);
    consume_pulse();

    // Below-threshold alternating frame, then saturated most-negative sample
    clear_det();
    for (int k = 0; k < FLEN; k++) step(1, 1, (k % 2 == 0) ? -10 : 10);
    step(1, 1, -32768);
    for (int k = 1; k < FLEN; k++) step(1, 1, 0);
    consume_pulse();

    // Hang-over sequence 2,1,0,0
    clear_det();
    frame(20); consume_pulse();
    for (int f = 0; f < 3; f++) begin
      frame(0); consume_pulse();
    end

    // Overrun on second unconsumed trigger
    clear_det();
    frame(20);
    frame(20);
    consume_pulse();

    // Consume edge coincident with frame-end trigger
    clear_det();
    frame(20);
    for (int k = 0; k < FLEN - 1; k++) step(1, 1, 20);
    sfb = 1; step(1, 1, 20);
    sfb = 0; step(1, 0, 0);
    consume_pulse();

    // Enable drop mid-frame, then a full frame, then async reset mid-frame
    clear_det();
    for (int k = 0; k < 5; k++) step(1, 1, 20);
    step(0, 0, 0);
    step(1, 0, 0);
    frame(20);
    for (int k = 0; k < 3; k++) step(1, 1, 20);
    async_reset();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom_range(0, 99) != 0);
      vld = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 39))
        0:       s = -32768;
        1, 2:    s = int'($urandom_range(0, 65535)) - 32768;
        default: s = int'($urandom_range(0, 400)) - 200;
      endcase
      thr = int'($urandom_range(0, 1600));
      if ($urandom_range(0, 9) == 0) sfb = ~sfb;
      step(en, vld, s);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
